red_centroid: RTL and testbench
===============================

# red_centroid

Per-frame centroid engine for the red-object tracker. It sits directly downstream of the pixel column/row `Mod_counter` pair. It takes the column and row counts, the pixel enable that drives the column counter, and a per-pixel red-detect flag. For each frame it accumulates the count and the coordinate sums of red pixels, then runs a sequential restoring divide to produce the (x, y) centroid once per frame. Results go to the overlay/servo logic.

## Interface
- `XW`, default 10: column coordinate width.
- `YW`, default 10: row coordinate width.
- `MIN_PIX`, default 16: minimum red-pixel count for a valid detection.
- `clk` in, 1: system clock; all logic on its rising edge.
- `reset_n` in, 1: reset, asynchronous, active-low.
- `pix_en` in, 1: pixel strobe, same signal as the column counter's clock enable.
- `col` in, XW: current column (column counter `q`).
- `row` in, YW: current row (row counter `q`).
- `is_red` in, 1: red classification of the current pixel; qualified by `pix_en`.
- `frame_end` in, 1: one-cycle pulse marking the last pixel of a frame.
- `cx` out, XW: centroid column, registered.
- `cy` out, YW: centroid row, registered.
- `found` out, 1: last result had count ≥ MIN_PIX.
- `result_valid` out, 1: one-cycle pulse when `cx`/`cy`/`found` update.
- `busy` out, 1: high while a snapshot is being processed.
- `overrun` out, 1: one-cycle pulse when a frame is dropped.

## Operation
- Accumulators:
  - `cnt`, width XW+YW.
  - `sum_x`, width 2·XW+YW.
  - `sum_y`, width XW+2·YW.
- On each cycle with `pix_en && is_red`: `cnt += 1`, `sum_x += col`, `sum_y += row`. Cycles with `pix_en`=0 are ignored regardless of `is_red`.
- No overflow handling is needed: a frame never exceeds 2^XW · 2^YW pixels.
- Accumulation and division overlap. On `frame_end`:
  - Accumulators are copied to snapshot registers (including that cycle's pixel if it qualifies).
  - Accumulators are cleared, so the next cycle starts a new frame from zero.
- FSM states: IDLE, CHECK, DIV_X, DIV_Y, DONE.
  - IDLE → CHECK on `frame_end`; snapshot taken.
  - CHECK: if snapshot `cnt` < MIN_PIX, go to DONE with `found`=0 and `cx`/`cy` unchanged. Otherwise go to DIV_X.
  - DIV_X: restoring division `sum_x / cnt`, one quotient bit per cycle, MSB first, XW cycles. Initial partial remainder = `sum_x >> XW`, which is always < `cnt`.
  - DIV_Y: same for `sum_y / cnt`, YW cycles.
  - DONE: register the quotients into `cx`/`cy`, set `found`=1 (or 0 on the skip path), pulse `result_valid`, return to IDLE.
- Quotients are truncated (floor); no rounding.
- `busy` = 1 in every state except IDLE.
- `frame_end` while `busy`:
  - Accumulators still clear, so the new frame starts.
  - No snapshot is taken; the in-flight computation is unaffected.
  - `overrun` pulses on the following cycle.
- `frame_end` in the same cycle the FSM returns from DONE to IDLE is treated as busy, i.e. an overrun.

## Timing
- Reset values, all outputs and state: `cx`=0, `cy`=0, `found`=0, `result_valid`=0, `busy`=0, `overrun`=0. Accumulators, snapshot and FSM are cleared; FSM is in IDLE.
- `reset_n` asserted mid-division aborts it immediately; no `result_valid` follows.
- `frame_end` at cycle T:
  - `busy`=1 from T+1.
  - Full path: `result_valid` at T+2+XW+YW (T+22 at defaults), with `cx`/`cy`/`found` valid in that same cycle. `busy`=0 at T+3+XW+YW.
  - Skip path (cnt < MIN_PIX): `result_valid` at T+2; `busy` drops at T+3.
- `cx`/`cy`/`found` hold their values between `result_valid` pulses.

## Test plan
- 16 red pixels all at (100, 50), then `frame_end` → 22 cycles later `result_valid`=1, `cx`=100, `cy`=50, `found`=1.
- Solid rectangle, cols 10–19 × rows 20–23 (40 pixels) → `cx`=14 (580/40), `cy`=21 (860/40), `found`=1.
- 15 red pixels, then `frame_end` → `result_valid` at T+2 with `found`=0; `cx`/`cy` keep their prior values.
- `is_red`=1 on every cycle but `pix_en`=1 on only 20 of them at (5, 5) → counts 20, `cx`=5, `cy`=5.
- 16 pixels at (1023, 1023) → `cx`=1023, `cy`=1023, with no overflow.
- Second `frame_end` 5 cycles after the first → `overrun` pulses and the first result is still correct. Separately, `reset_n` low during DIV_Y → all outputs 0 and no `result_valid`.

Source files
------------

// File: rtl/red_centroid.sv
// Per-frame red-pixel centroid: accumulates count and coordinate sums, then runs a
// restoring divide (X then Y) that overlaps accumulation of the next frame.
module red_centroid #(
   parameter int XW      = 10,
   parameter int YW      = 10,
   parameter int MIN_PIX = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          pix_en,
   input  logic [XW-1:0] col,
   input  logic [YW-1:0] row,
   input  logic          is_red,
   input  logic          frame_end,
   output logic [XW-1:0] cx,
   output logic [YW-1:0] cy,
   output logic          found,
   output logic          result_valid,
   output logic          busy,
   output logic          overrun
);

   localparam int CW  = XW + YW;
   localparam int SXW = 2 * XW + YW;
   localparam int SYW = XW + 2 * YW;
   localparam int LW  = (XW > YW) ? XW : YW;
   localparam int SW  = $clog2(LW + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_DIV_X = 3'd2,
      S_DIV_Y = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [CW-1:0]    r_cnt;
   logic [SXW-1:0]   r_sum_x;
   logic [SYW-1:0]   r_sum_y;
   logic [CW-1:0]    r_snap_cnt;
   logic [SXW-1:0]   r_snap_x;
   logic [SYW-1:0]   r_snap_y;

   logic [CW-1:0]    r_rem;
   logic [LW-1:0]    r_lo;
   logic [LW-2:0]    r_quot;
   logic [XW-1:0]    r_qx;
   logic [SW-1:0]    r_step;

   logic [XW-1:0]    r_cx;
   logic [YW-1:0]    r_cy;
   logic             r_found;
   logic             r_rv;
   logic             r_busy;
   logic             r_overrun;

   logic             w_qual;
   logic             w_take;
   logic [CW-1:0]    w_cnt_nxt;
   logic [SXW-1:0]   w_sum_x_nxt;
   logic [SYW-1:0]   w_sum_y_nxt;
   logic [CW:0]      w_trial;
   logic             w_ge;
   logic [CW-1:0]    w_rem_nxt;
   logic [LW-1:0]    w_quot_nxt;
   logic             w_last_x;
   logic             w_last_y;
   logic             w_skip;

   assign w_qual      = pix_en & is_red;
   assign w_take      = frame_end & (r_state == S_IDLE);
   assign w_cnt_nxt   = r_cnt + (w_qual ? {{(CW-1){1'b0}}, 1'b1} : {CW{1'b0}});
   assign w_sum_x_nxt = r_sum_x + (w_qual ? SXW'(col) : {SXW{1'b0}});
   assign w_sum_y_nxt = r_sum_y + (w_qual ? SYW'(row) : {SYW{1'b0}});

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   assign w_trial    = {r_rem, r_lo[LW-1]};
   assign w_ge       = (w_trial >= {1'b0, r_snap_cnt});
   assign w_rem_nxt  = w_ge ? CW'(w_trial - {1'b0, r_snap_cnt}) : w_trial[CW-1:0];
   assign w_quot_nxt = {r_quot, w_ge};
   assign w_last_x   = (r_step == SW'(XW - 1));
   assign w_last_y   = (r_step == SW'(YW - 1));
   assign w_skip     = (r_snap_cnt < CW'(MIN_PIX));

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (frame_end) w_state_nxt = S_CHECK;
            else           w_state_nxt = S_IDLE;
         end
         S_CHECK: begin
            if (w_skip) w_state_nxt = S_DONE;
            else        w_state_nxt = S_DIV_X;
         end
         S_DIV_X: begin
            if (w_last_x) w_state_nxt = S_DIV_Y;
            else          w_state_nxt = S_DIV_X;
         end
         S_DIV_Y: begin
            if (w_last_y) w_state_nxt = S_DONE;
            else          w_state_nxt = S_DIV_Y;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Frame accumulators; every frame_end starts a new frame even when busy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= {CW{1'b0}};
         r_sum_x <= {SXW{1'b0}};
         r_sum_y <= {SYW{1'b0}};
      end else if (frame_end) begin
         r_cnt   <= {CW{1'b0}};
         r_sum_x <= {SXW{1'b0}};
         r_sum_y <= {SYW{1'b0}};
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_sum_x <= w_sum_x_nxt;
         r_sum_y <= w_sum_y_nxt;
      end
   end

   // Snapshot includes the frame_end cycle's own pixel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_snap_cnt <= {CW{1'b0}};
         r_snap_x   <= {SXW{1'b0}};
         r_snap_y   <= {SYW{1'b0}};
      end else if (w_take) begin
         r_snap_cnt <= w_cnt_nxt;
         r_snap_x   <= w_sum_x_nxt;
         r_snap_y   <= w_sum_y_nxt;
      end else begin
         r_snap_cnt <= r_snap_cnt;
         r_snap_x   <= r_snap_x;
         r_snap_y   <= r_snap_y;
      end
   end

   // Divider datapath shared between the X and Y passes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rem  <= {CW{1'b0}};
         r_lo   <= {LW{1'b0}};
         r_quot <= {(LW-1){1'b0}};
         r_qx   <= {XW{1'b0}};
         r_step <= {SW{1'b0}};
      end else begin
         case (r_state)
            S_CHECK: begin
               r_rem  <= r_snap_x[SXW-1:XW];
               r_lo   <= LW'(r_snap_x[XW-1:0]) << (LW - XW);
               r_quot <= {(LW-1){1'b0}};
               r_step <= {SW{1'b0}};
            end
            S_DIV_X: begin
               if (w_last_x) begin
                  r_qx   <= w_quot_nxt[XW-1:0];
                  r_rem  <= r_snap_y[SYW-1:YW];
                  r_lo   <= LW'(r_snap_y[YW-1:0]) << (LW - YW);
                  r_quot <= {(LW-1){1'b0}};
                  r_step <= {SW{1'b0}};
               end else begin
                  r_rem  <= w_rem_nxt;
                  r_lo   <= r_lo << 1;
                  r_quot <= w_quot_nxt[LW-2:0];
                  r_step <= r_step + SW'(1);
               end
            end
            S_DIV_Y: begin
               r_rem  <= w_rem_nxt;
               r_lo   <= r_lo << 1;
               r_quot <= w_quot_nxt[LW-2:0];
               r_step <= r_step + SW'(1);
            end
            default: begin
               r_rem  <= r_rem;
               r_lo   <= r_lo;
               r_quot <= r_quot;
               r_step <= r_step;
            end
         endcase
      end
   end

   // Result/status registers; results land on the edge entering DONE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cx      <= {XW{1'b0}};
         r_cy      <= {YW{1'b0}};
         r_found   <= 1'b0;
         r_rv      <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_busy    <= (w_state_nxt != S_IDLE);
         r_overrun <= frame_end & (r_state != S_IDLE);
         if (r_state == S_CHECK && w_skip) begin
            r_found <= 1'b0;
            r_rv    <= 1'b1;
         end else if (r_state == S_DIV_Y && w_last_y) begin
            r_cx    <= r_qx;
            r_cy    <= w_quot_nxt[YW-1:0];
            r_found <= 1'b1;
            r_rv    <= 1'b1;
         end else begin
            r_rv    <= 1'b0;
         end
      end
   end

   assign cx           = r_cx;
   assign cy           = r_cy;
   assign found        = r_found;
   assign result_valid = r_rv;
   assign busy         = r_busy;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_red_centroid.sv
// Bench for red_centroid: an event-level frame model predicts each result and its
// cycle of arrival; outputs are compared every cycle plus directed literal checks.
module tb_red_centroid;
   localparam int XW = 10, YW = 10, MIN_PIX = 16, L = XW + YW;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          pix_en = 1'b0, is_red = 1'b0, frame_end = 1'b0;
   logic [XW-1:0] col = '0;
   logic [YW-1:0] row = '0;
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic          found, result_valid, busy, overrun;

   always #5 clk = ~clk;

   red_centroid #(.XW(XW), .YW(YW), .MIN_PIX(MIN_PIX)) dut (
      .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .col(col), .row(row),
      .is_red(is_red), .frame_end(frame_end), .cx(cx), .cy(cy), .found(found),
      .result_valid(result_valid), .busy(busy), .overrun(overrun));

   // Model: running frame sums, plus the one job in flight (start edge, result edge).
   longint m_cnt, m_sx, m_sy;
   int     n_edge;
   bit     job_v, job_found;
   int     job_s, job_r, job_cx, job_cy;
   int     exp_cx, exp_cy;
   bit     exp_found, exp_ovr;
   int     n_pass = 0, n_chk = 0, rv_seen = 0;
   bit     chk_en = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit m_busy(input int m);
      return job_v && (job_s <= m) && (m <= job_r);
   endfunction

   task automatic model_clear();
      m_cnt = 0; m_sx = 0; m_sy = 0;
      job_v = 1'b0; job_found = 1'b0; job_s = 0; job_r = 0; job_cx = 0; job_cy = 0;
      exp_cx = 0; exp_cy = 0; exp_found = 1'b0; exp_ovr = 1'b0;
   endtask

   task automatic model_edge(input bit pe, input int c, input int r, input bit red, input bit fe);
      bit busy_prev;
      n_edge++;
      busy_prev = m_busy(n_edge - 1);
      if (pe && red) begin
         m_cnt++; m_sx += c; m_sy += r;
      end
      exp_ovr = fe && busy_prev;
      if (job_v && n_edge == job_r) begin
         if (job_found) begin
            exp_cx = job_cx; exp_cy = job_cy;
         end
         exp_found = job_found;
      end
      if (fe) begin
         if (!busy_prev) begin
            job_v = 1'b1;
            job_s = n_edge;
            if (m_cnt < MIN_PIX) begin
               job_found = 1'b0;
               job_r     = n_edge + 1;
            end else begin
               job_found = 1'b1;
               job_cx    = int'(m_sx / m_cnt);
               job_cy    = int'(m_sy / m_cnt);
               job_r     = n_edge + 1 + L;
            end
         end
         m_cnt = 0; m_sx = 0; m_sy = 0;
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("result_valid", result_valid, longint'(job_v && n_edge == job_r));
         chk("busy", busy, longint'(m_busy(n_edge)));
         chk("overrun", overrun, longint'(exp_ovr));
         chk("cx", cx, exp_cx);
         chk("cy", cy, exp_cy);
         chk("found", found, longint'(exp_found));
         if (result_valid) rv_seen++;
      end
   end

   task automatic cyc(input bit pe, input int c, input int r, input bit red, input bit fe);
      pix_en = pe; col = XW'(c); row = YW'(r); is_red = red; frame_end = fe;
      @(posedge clk);
      model_edge(pe, c, r, red, fe);
      #1;
      pix_en = 1'b0; is_red = 1'b0; frame_end = 1'b0;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic pixels(input int k, input int c, input int r);
      for (int i = 0; i < k; i++) cyc(1'b1, c, r, 1'b1, 1'b0);
   endtask

   task automatic wait_rv(input string name, input int exp_lat);
      int k;
      k = 0;
      do begin
         cyc(1'b0, 0, 0, 1'b0, 1'b0);
         k++;
      end while (!result_valid && k < 60);
      chk({name, " latency"}, k, exp_lat);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_clear();
      #1;
      chk("rst cx", cx, 0);
      chk("rst cy", cy, 0);
      chk("rst found", found, 0);
      chk("rst busy", busy, 0);
      chk("rst rv", result_valid, 0);
      chk("rst overrun", overrun, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int rv0, npix;
      model_clear();
      n_edge = 0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      do_reset();

      // 16 pixels at a single point.
      pixels(16, 100, 50);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);
      wait_rv("point", 21);
      chk("point cx", cx, 100); chk("point cy", cy, 50); chk("point found", found, 1);

      // Solid rectangle, 10..19 x 20..23.
      for (int r = 20; r < 24; r++)
         for (int c = 10; c < 20; c++) cyc(1'b1, c, r, 1'b1, 1'b0);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);
      wait_rv("rect", 21);
      chk("rect cx", cx, 14); chk("rect cy", cy, 21); chk("rect found", found, 1);

      // Below threshold: skip path keeps previous centroid.
      pixels(15, 7, 9);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);
      wait_rv("skip", 1);
      chk("skip found", found, 0); chk("skip cx", cx, 14); chk("skip cy", cy, 21);

      // is_red always high, pix_en on only 20 cycles.
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 0) cyc(1'b1, 5, 5, 1'b1, 1'b0);
         else            cyc(1'b0, 900, 900, 1'b1, 1'b0);
      end
      cyc(1'b0, 900, 900, 1'b1, 1'b1);
      wait_rv("pixen", 21);
      chk("pixen cx", cx, 5); chk("pixen cy", cy, 5); chk("pixen found", found, 1);

      // Maximum coordinates.
      pixels(16, 1023, 1023);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);
      wait_rv("max", 21);
      chk("max cx", cx, 1023); chk("max cy", cy, 1023);

      // Second frame_end 5 cycles after the first is dropped.
      pixels(16, 200, 300);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);
      pixels(4, 600, 600);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);
      chk("overrun pulse", overrun, 1);
      wait_rv("ovr", 16);
      chk("ovr cx", cx, 200); chk("ovr cy", cy, 300);
      idle(1);
      chk("ovr busy after", busy, 0);
      pixels(16, 3, 4);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);
      wait_rv("post ovr", 21);
      chk("post ovr cx", cx, 3); chk("post ovr cy", cy, 4);

      // Reset during DIV_Y aborts the computation.
      pixels(20, 40, 60);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);
      idle(14);
      chk("divy busy", busy, 1);
      rv0 = rv_seen;
      do_reset();
      idle(30);
      chk("no rv after reset", rv_seen - rv0, 0);

      // Randomized frames, including overlapping frame_ends.
      for (int f = 0; f < 40; f++) begin
         npix = $urandom_range(0, 45);
         for (int i = 0; i <= npix; i++) begin
            if (f % 2 == 0)
               cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1023), $urandom_range(0, 1023),
                   1'($urandom_range(0, 1)), i == npix);
            else
               cyc($urandom_range(0, 3) != 0, $urandom_range(500, 520), $urandom_range(0, 15),
                   $urandom_range(0, 4) != 0, i == npix);
         end
         idle($urandom_range(0, 25));
      end
      idle(30);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
